ysyx_25040129_icache_2way: RTL and testbench

YSYX_25040129_ICACHE_2WAY -- requirements
Module: ysyx_25040129_icache_2way

---
 rtl/ysyx_25040129_icache_2way.sv | 229 ++++++++++++++++++++++
 tb/tb_ysyx_25040129_icache_2way.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25040129_icache_2way.sv
// Two-way set-associative instruction cache with LRU replacement and INCR-burst refill.
// Optional macro YSYX_25040129_ICACHE_SATP_TAG_EN adds satp[31:12] to each line's tag.
module ysyx_25040129_icache_2way #(
   parameter int unsigned SET_DIG = 3,
   parameter int unsigned OFF_DIG = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] ifu_araddr,
   input  logic        ifu_arvalid,
   output logic        ifu_arready,
   output logic [31:0] ifu_rdata,
   output logic [1:0]  ifu_rresp,
   output logic        ifu_rvalid,
   input  logic        ifu_rready,
   output logic [31:0] out_araddr,
   output logic        out_arvalid,
   input  logic        out_arready,
   output logic [7:0]  out_arlen,
   output logic [1:0]  out_arburst,
   input  logic [31:0] out_rdata,
   input  logic [1:0]  out_rresp,
   input  logic        out_rvalid,
   output logic        out_rready,
   input  logic        out_rlast,
   input  logic        fence_i,
   input  logic [31:0] satp
);

   localparam int unsigned WORDS  = 1 << (OFF_DIG - 2);
   localparam int unsigned SETS   = 1 << SET_DIG;
   localparam int unsigned TAG_W  = 32 - OFF_DIG - SET_DIG;
   localparam int unsigned WORD_W = (OFF_DIG > 2) ? OFF_DIG - 2 : 1;
   localparam logic [31:0] WORD_MASK = 32'(WORDS - 1);
   localparam logic [WORD_W-1:0] CNT_MAX = WORD_W'(WORDS - 1);

   localparam logic [1:0] S_IDLE     = 2'd0;
   localparam logic [1:0] S_WAIT_IFU = 2'd1;
   localparam logic [1:0] S_WAIT_AR  = 2'd2;
   localparam logic [1:0] S_WAIT_R   = 2'd3;

   logic [1:0]        state_q, state_d;
   logic [31:0]       addr_q, addr_d;
   logic [31:0]       rdata_q, rdata_d;
   logic [1:0]        rresp_q, rresp_d;
   logic [WORD_W-1:0] cnt_q, cnt_d;
   logic              victim_q, victim_d;
   logic              flush_pending_q, flush_pending_d;
   logic [SETS-1:0]   valid0_q, valid0_d;
   logic [SETS-1:0]   valid1_q, valid1_d;
   logic [SETS-1:0]   lru_q, lru_d;

   logic [31:0]       data_mem [2][SETS][WORDS];
   logic [TAG_W-1:0]  tag_mem  [2][SETS];

   logic [SET_DIG-1:0] lk_idx;
   logic [TAG_W-1:0]   lk_tag;
   logic [WORD_W-1:0]  lk_word;
   logic [SET_DIG-1:0] rf_idx;
   logic [TAG_W-1:0]   rf_tag;
   logic [WORD_W-1:0]  rf_word;
   logic               hit0, hit1, hit_way, lookup_hit;
   logic [31:0]        hit_data;
   logic               mem_we, tag_we;

   assign lk_idx  = ifu_araddr[OFF_DIG+SET_DIG-1:OFF_DIG];
   assign lk_tag  = ifu_araddr[31:OFF_DIG+SET_DIG];
   assign lk_word = WORD_W'((ifu_araddr >> 2) & WORD_MASK);
   assign rf_idx  = addr_q[OFF_DIG+SET_DIG-1:OFF_DIG];
   assign rf_tag  = addr_q[31:OFF_DIG+SET_DIG];
   assign rf_word = WORD_W'((addr_q >> 2) & WORD_MASK);

`ifdef YSYX_25040129_ICACHE_SATP_TAG_EN
   logic [19:0] satp_mem [2][SETS];
   logic        unused_bits;
   assign unused_bits = ^satp[11:0];
   assign hit0 = valid0_q[lk_idx] && (tag_mem[0][lk_idx] == lk_tag) && (satp_mem[0][lk_idx] == satp[31:12]);
   assign hit1 = valid1_q[lk_idx] && (tag_mem[1][lk_idx] == lk_tag) && (satp_mem[1][lk_idx] == satp[31:12]);
`else
   logic        unused_bits;
   assign unused_bits = ^satp;
   assign hit0 = valid0_q[lk_idx] && (tag_mem[0][lk_idx] == lk_tag);
   assign hit1 = valid1_q[lk_idx] && (tag_mem[1][lk_idx] == lk_tag);
`endif

   assign hit_way    = ~hit0;
   assign hit_data   = data_mem[hit_way][lk_idx][lk_word];
   assign lookup_hit = (state_q == S_IDLE) && ifu_arvalid && ifu_arready && (hit0 || hit1);

   // Handshake outputs: the hit path answers in the same cycle as the request.
   assign ifu_arready = (state_q == S_IDLE) && !fence_i && !flush_pending_q;
   assign ifu_rvalid  = lookup_hit || (state_q == S_WAIT_IFU);
   assign ifu_rdata   = (state_q == S_WAIT_IFU) ? rdata_q : hit_data;
   assign ifu_rresp   = (state_q == S_WAIT_IFU) ? rresp_q : 2'b00;
   assign out_arvalid = (state_q == S_WAIT_AR);
   assign out_araddr  = {addr_q[31:OFF_DIG], {OFF_DIG{1'b0}}};
   assign out_arlen   = 8'(WORDS - 1);
   assign out_arburst = 2'b01;
   assign out_rready  = (state_q == S_WAIT_R);

   // Next-state logic for control, LRU and valid bits.
   always_comb begin
      state_d         = state_q;
      addr_d          = addr_q;
      rdata_d         = rdata_q;
      rresp_d         = rresp_q;
      cnt_d           = cnt_q;
      victim_d        = victim_q;
      flush_pending_d = flush_pending_q;
      valid0_d        = valid0_q;
      valid1_d        = valid1_q;
      lru_d           = lru_q;
      mem_we          = 1'b0;
      tag_we          = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (fence_i || flush_pending_q) begin
               valid0_d        = '0;
               valid1_d        = '0;
               flush_pending_d = 1'b0;
            end else if (ifu_arvalid) begin
               if (hit0 || hit1) begin
                  lru_d[lk_idx] = ~hit_way;
                  if (!ifu_rready) begin
                     state_d = S_WAIT_IFU;
                     rdata_d = hit_data;
                     rresp_d = 2'b00;
                  end
               end else begin
                  addr_d  = ifu_araddr;
                  rresp_d = 2'b00;
                  state_d = S_WAIT_AR;
                  if (!valid0_q[lk_idx]) begin
                     victim_d = 1'b0;
                  end else if (!valid1_q[lk_idx]) begin
                     victim_d = 1'b1;
                  end else begin
                     victim_d = lru_q[lk_idx];
                  end
               end
            end
         end
         S_WAIT_AR: begin
            if (out_arready) begin
               state_d = S_WAIT_R;
               cnt_d   = '0;
            end
         end
         S_WAIT_R: begin
            if (out_rvalid) begin
               mem_we = 1'b1;
               if (cnt_q != CNT_MAX) begin
                  cnt_d = cnt_q + WORD_W'(1);
               end
               if (rresp_q == 2'b00) begin
                  rresp_d = out_rresp;
               end
               if (cnt_q == rf_word) begin
                  rdata_d = out_rdata;
               end
               // A line that saw any error beat is never marked valid.
               if (out_rlast) begin
                  tag_we        = 1'b1;
                  lru_d[rf_idx] = ~victim_q;
                  state_d       = S_WAIT_IFU;
                  if ((rresp_q == 2'b00) && (out_rresp == 2'b00)) begin
                     if (victim_q) begin
                        valid1_d[rf_idx] = 1'b1;
                     end else begin
                        valid0_d[rf_idx] = 1'b1;
                     end
                  end
               end
            end
         end
         S_WAIT_IFU: begin
            if (ifu_rready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (fence_i && (state_q != S_IDLE)) begin
         flush_pending_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= S_IDLE;
         addr_q          <= '0;
         rdata_q         <= '0;
         rresp_q         <= 2'b00;
         cnt_q           <= '0;
         victim_q        <= 1'b0;
         flush_pending_q <= 1'b0;
         valid0_q        <= '0;
         valid1_q        <= '0;
         lru_q           <= '0;
      end else begin
         state_q         <= state_d;
         addr_q          <= addr_d;
         rdata_q         <= rdata_d;
         rresp_q         <= rresp_d;
         cnt_q           <= cnt_d;
         victim_q        <= victim_d;
         flush_pending_q <= flush_pending_d;
         valid0_q        <= valid0_d;
         valid1_q        <= valid1_d;
         lru_q           <= lru_d;
      end
   end

   // Data/tag arrays carry no reset; validity is tracked by the valid bits.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         data_mem[victim_q][rf_idx][cnt_q] <= out_rdata;
      end
      if (tag_we) begin
         tag_mem[victim_q][rf_idx] <= rf_tag;
`ifdef YSYX_25040129_ICACHE_SATP_TAG_EN
         satp_mem[victim_q][rf_idx] <= satp[31:12];
`endif
      end
   end

endmodule

// File: tb/tb_ysyx_25040129_icache_2way.sv
// Directed bench for the two-way icache: vector table of reads plus hand sequences
// for stalled IFU, fence in IDLE, stray refill beats and reset during refill.
module tb_ysyx_25040129_icache_2way;

   localparam logic [31:0] KEY = 32'h1234_5678;

   logic        clk, rst;
   logic [31:0] ifu_araddr;
   logic        ifu_arvalid, ifu_arready;
   logic [31:0] ifu_rdata;
   logic [1:0]  ifu_rresp;
   logic        ifu_rvalid, ifu_rready;
   logic [31:0] out_araddr;
   logic        out_arvalid, out_arready;
   logic [7:0]  out_arlen;
   logic [1:0]  out_arburst;
   logic [31:0] out_rdata;
   logic [1:0]  out_rresp;
   logic        out_rvalid, out_rready, out_rlast;
   logic        fence_i;
   logic [31:0] satp;

   int total = 0;
   int bad   = 0;
   int ar_cnt = 0;

   ysyx_25040129_icache_2way #(.SET_DIG(3), .OFF_DIG(4)) dut (
      .clk(clk), .rst(rst),
      .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
      .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready),
      .out_araddr(out_araddr), .out_arvalid(out_arvalid), .out_arready(out_arready),
      .out_arlen(out_arlen), .out_arburst(out_arburst),
      .out_rdata(out_rdata), .out_rresp(out_rresp), .out_rvalid(out_rvalid),
      .out_rready(out_rready), .out_rlast(out_rlast),
      .fence_i(fence_i), .satp(satp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (out_arvalid && out_arready) ar_cnt <= ar_cnt + 1;
   end

   typedef struct {
      logic [31:0] addr;
      int          fence_at;
      int          err_at;
      logic        exp_miss;
      logic [31:0] exp_araddr;
      logic [31:0] exp_data;
      logic [1:0]  exp_resp;
   } vec_t;

   vec_t vecs[16];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %08h want %08h", nm, act, exp);
      end
   endtask

   // One IFU read; on a miss, plays the memory side of the 4-beat burst.
   task automatic do_read(input vec_t v, input string nm);
      int          k;
      int          ar0;
      logic        hit;
      logic [31:0] base;
      ar0 = ar_cnt;
      ifu_araddr  = v.addr;
      ifu_arvalid = 1'b1;
      ifu_rready  = 1'b1;
      #1;
      k = 0;
      while (!ifu_arready && k < 20) begin
         @(negedge clk); #1; k++;
      end
      chk({nm, ".arready"}, 32'(ifu_arready), 32'd1);
      hit = ifu_rvalid;
      chk({nm, ".miss"}, 32'(!hit), 32'(v.exp_miss));
      if (hit) begin
         chk({nm, ".hit_data"}, ifu_rdata, v.exp_data);
         chk({nm, ".hit_resp"}, 32'(ifu_rresp), 32'(v.exp_resp));
         @(posedge clk); @(negedge clk);
         ifu_arvalid = 1'b0;
      end else begin
         @(posedge clk); @(negedge clk);
         ifu_arvalid = 1'b0;
         #1;
         k = 0;
         while (!out_arvalid && k < 20) begin
            @(negedge clk); #1; k++;
         end
         chk({nm, ".arvalid"}, 32'(out_arvalid), 32'd1);
         chk({nm, ".araddr"}, out_araddr, v.exp_araddr);
         chk({nm, ".arlen"}, 32'(out_arlen), 32'd3);
         chk({nm, ".arburst"}, 32'(out_arburst), 32'd1);
         chk({nm, ".rready_ar"}, 32'(out_rready), 32'd0);
         base = out_araddr;
         out_arready = 1'b1;
         @(posedge clk); @(negedge clk);
         out_arready = 1'b0;
         for (int b = 0; b < 4; b++) begin
            out_rvalid = 1'b1;
            out_rdata  = (base + 32'(4 * b)) ^ KEY;
            out_rresp  = (b == v.err_at) ? 2'b10 : 2'b00;
            out_rlast  = (b == 3);
            fence_i    = (b == v.fence_at);
            #1;
            if (b == 0) chk({nm, ".rready"}, 32'(out_rready), 32'd1);
            @(posedge clk); @(negedge clk);
         end
         out_rvalid = 1'b0;
         out_rlast  = 1'b0;
         out_rresp  = 2'b00;
         fence_i    = 1'b0;
         #1;
         chk({nm, ".rvalid"}, 32'(ifu_rvalid), 32'd1);
         chk({nm, ".data"}, ifu_rdata, v.exp_data);
         chk({nm, ".resp"}, 32'(ifu_rresp), 32'(v.exp_resp));
         @(posedge clk); @(negedge clk);
      end
      chk({nm, ".ar_count"}, 32'(ar_cnt - ar0), v.exp_miss ? 32'd1 : 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: got running want finished");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t v;
      // addr, fence_at, err_at, miss, araddr, data, resp
      vecs[0]  = '{32'h8000_0000, -1, -1, 1'b1, 32'h8000_0000, 32'h9234_5678, 2'b00};
      vecs[1]  = '{32'h8000_0008, -1, -1, 1'b0, 32'h0,         32'h9234_5670, 2'b00};
      vecs[2]  = '{32'h8000_0080, -1, -1, 1'b1, 32'h8000_0080, 32'h9234_56F8, 2'b00};
      vecs[3]  = '{32'h8000_0004, -1, -1, 1'b0, 32'h0,         32'h9234_567C, 2'b00};
      vecs[4]  = '{32'h8000_0100, -1, -1, 1'b1, 32'h8000_0100, 32'h9234_5778, 2'b00};
      vecs[5]  = '{32'h8000_000C, -1, -1, 1'b0, 32'h0,         32'h9234_5674, 2'b00};
      vecs[6]  = '{32'h8000_0084, -1, -1, 1'b1, 32'h8000_0080, 32'h9234_56FC, 2'b00};
      vecs[7]  = '{32'h8000_0104, -1, -1, 1'b1, 32'h8000_0100, 32'h9234_577C, 2'b00};
      vecs[8]  = '{32'h8000_0088, -1, -1, 1'b0, 32'h0,         32'h9234_56F0, 2'b00};
      vecs[9]  = '{32'h8000_0040,  1, -1, 1'b1, 32'h8000_0040, 32'h9234_5638, 2'b00};
      vecs[10] = '{32'h8000_0040, -1, -1, 1'b1, 32'h8000_0040, 32'h9234_5638, 2'b00};
      vecs[11] = '{32'h8000_0088, -1, -1, 1'b1, 32'h8000_0080, 32'h9234_56F0, 2'b00};
      vecs[12] = '{32'h8000_0204, -1,  1, 1'b1, 32'h8000_0200, 32'h9234_547C, 2'b10};
      vecs[13] = '{32'h8000_0204, -1, -1, 1'b1, 32'h8000_0200, 32'h9234_547C, 2'b00};
      vecs[14] = '{32'h8000_0208, -1, -1, 1'b0, 32'h0,         32'h9234_5470, 2'b00};
      vecs[15] = '{32'h8000_03FC, -1, -1, 1'b1, 32'h8000_03F0, 32'h9234_5584, 2'b00};

      rst = 1'b1; ifu_araddr = '0; ifu_arvalid = 1'b0; ifu_rready = 1'b0;
      out_arready = 1'b0; out_rdata = '0; out_rresp = 2'b00; out_rvalid = 1'b0;
      out_rlast = 1'b0; fence_i = 1'b0; satp = 32'h8000_1000;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("reset.arready", 32'(ifu_arready), 32'd1);
      chk("reset.rvalid", 32'(ifu_rvalid), 32'd0);
      chk("reset.arvalid", 32'(out_arvalid), 32'd0);
      chk("reset.rready", 32'(out_rready), 32'd0);
      chk("reset.rresp", 32'(ifu_rresp), 32'd0);

      for (int i = 0; i < 16; i++) begin
         do_read(vecs[i], $sformatf("v%0d", i));
      end

      // Hit while the IFU stalls: data must be held in WAIT_IFU.
      ifu_araddr = 32'h8000_0208; ifu_arvalid = 1'b1; ifu_rready = 1'b0;
      #1;
      chk("stall.rvalid0", 32'(ifu_rvalid), 32'd1);
      chk("stall.data0", ifu_rdata, 32'h9234_5470);
      @(posedge clk); @(negedge clk);
      ifu_arvalid = 1'b0;
      #1;
      chk("stall.rvalid1", 32'(ifu_rvalid), 32'd1);
      chk("stall.data1", ifu_rdata, 32'h9234_5470);
      chk("stall.arready1", 32'(ifu_arready), 32'd0);
      ifu_rready = 1'b1;
      @(posedge clk); @(negedge clk);
      #1;
      chk("stall.rvalid2", 32'(ifu_rvalid), 32'd0);
      chk("stall.arready2", 32'(ifu_arready), 32'd1);

      // fence_i in IDLE blocks lookup this cycle and flushes the cache.
      @(negedge clk);
      fence_i = 1'b1; ifu_araddr = 32'h8000_0208; ifu_arvalid = 1'b1;
      #1;
      chk("fence.arready", 32'(ifu_arready), 32'd0);
      chk("fence.rvalid", 32'(ifu_rvalid), 32'd0);
      @(posedge clk); @(negedge clk);
      fence_i = 1'b0; ifu_arvalid = 1'b0;
      v = '{32'h8000_0208, -1, -1, 1'b1, 32'h8000_0200, 32'h9234_5470, 2'b00};
      do_read(v, "fence_reread");

      // Stray refill beat in IDLE must be ignored.
      out_rvalid = 1'b1; out_rlast = 1'b1; out_rdata = 32'hDEAD_BEEF;
      #1;
      chk("stray.rready", 32'(out_rready), 32'd0);
      @(posedge clk); @(negedge clk);
      out_rvalid = 1'b0; out_rlast = 1'b0;
      #1;
      chk("stray.rvalid", 32'(ifu_rvalid), 32'd0);
      chk("stray.arready", 32'(ifu_arready), 32'd1);
      v = '{32'h8000_020C, -1, -1, 1'b0, 32'h0, 32'h9234_5474, 2'b00};
      do_read(v, "stray_hit");

      // Reset in the middle of a refill abandons the line.
      ifu_araddr = 32'h8000_0500; ifu_arvalid = 1'b1; ifu_rready = 1'b1;
      @(posedge clk); @(negedge clk);
      ifu_arvalid = 1'b0; out_arready = 1'b1;
      #1;
      chk("midrst.arvalid", 32'(out_arvalid), 32'd1);
      @(posedge clk); @(negedge clk);
      out_arready = 1'b0; out_rvalid = 1'b1; out_rdata = 32'h9234_5378;
      @(posedge clk); @(negedge clk);
      out_rvalid = 1'b0; rst = 1'b1;
      @(posedge clk); @(negedge clk);
      rst = 1'b0;
      #1;
      chk("midrst.arready", 32'(ifu_arready), 32'd1);
      chk("midrst.rready", 32'(out_rready), 32'd0);
      chk("midrst.arvalid2", 32'(out_arvalid), 32'd0);
      chk("midrst.rvalid", 32'(ifu_rvalid), 32'd0);
      v = '{32'h8000_0500, -1, -1, 1'b1, 32'h8000_0500, 32'h9234_5378, 2'b00};
      do_read(v, "midrst_reread");
      v = '{32'h8000_0000, -1, -1, 1'b1, 32'h8000_0000, 32'h9234_5678, 2'b00};
      do_read(v, "post_rst_miss");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
